// File: rtl/alu_if.sv
// Operand/result bundle for the lane ALU; `zero`/`carry` exist only when ALU_FLAGS_EN is defined.
interface alu_if #(
  parameter int unsigned S  = 4,
  parameter int unsigned T1 = 8,
  parameter int unsigned T2 = 1
);
  localparam int unsigned W = T1 * T2;

  logic [S-1:0] op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] out;
`ifdef ALU_FLAGS_EN
  logic          zero;
  logic [T2-1:0] carry;

  modport master (output op, output in1, output in2, input out, input zero, input carry);
  modport slave  (input op, input in1, input in2, output out, output zero, output carry);
`else
  modport master (output op, output in1, output in2, input out);
  modport slave  (input op, input in1, input in2, output out);
`endif
endinterface

// File: rtl/alu.sv
// Registered SIMD lane ALU: 16 ops per T1-bit lane, 1-cycle latency, synchronous active-high reset.
// Optional registered zero/carry flags are enabled by defining ALU_FLAGS_EN.
module alu #(
  parameter int unsigned S  = 4,
  parameter int unsigned T1 = 8,
  parameter int unsigned T2 = 1
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);
  localparam int unsigned W  = T1 * T2;
  // Opcode compared at >=5 bits so values >=16 fall to the zero default when S>4.
  localparam int unsigned OW = (S > 5) ? S : 5;

  localparam logic [OW-1:0] OP_ADD  = OW'(0);
  localparam logic [OW-1:0] OP_SUB  = OW'(1);
  localparam logic [OW-1:0] OP_INC  = OW'(2);
  localparam logic [OW-1:0] OP_DEC  = OW'(3);
  localparam logic [OW-1:0] OP_SHL  = OW'(4);
  localparam logic [OW-1:0] OP_SHR  = OW'(5);
  localparam logic [OW-1:0] OP_AND  = OW'(6);
  localparam logic [OW-1:0] OP_NAND = OW'(7);
  localparam logic [OW-1:0] OP_OR   = OW'(8);
  localparam logic [OW-1:0] OP_NOR  = OW'(9);
  localparam logic [OW-1:0] OP_XOR  = OW'(10);
  localparam logic [OW-1:0] OP_XNOR = OW'(11);
  localparam logic [OW-1:0] OP_NOT  = OW'(12);
  localparam logic [OW-1:0] OP_PASS = OW'(13);
  localparam logic [OW-1:0] OP_ROL  = OW'(14);
  localparam logic [OW-1:0] OP_ROR  = OW'(15);

  logic [OW-1:0] op_w;
  logic [W-1:0]  res;
`ifdef ALU_FLAGS_EN
  logic [T2-1:0] cy;
`endif

  assign op_w = OW'(bus.op);

  for (genvar k = 0; k < int'(T2); k++) begin : g_lane
    logic [T1-1:0] a;
    logic [T1-1:0] b;
    logic [T1-1:0] r;

    assign a = bus.in1[k*T1 +: T1];
    assign b = bus.in2[k*T1 +: T1];

    // Per-lane result; nothing crosses the lane boundary.
    always_comb begin
      r = '0;
      case (op_w)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        OP_INC:  r = a + T1'(1);
        OP_DEC:  r = a - T1'(1);
        OP_SHL:  r = {a[T1-2:0], 1'b0};
        OP_SHR:  r = {1'b0, a[T1-1:1]};
        OP_AND:  r = a & b;
        OP_NAND: r = ~(a & b);
        OP_OR:   r = a | b;
        OP_NOR:  r = ~(a | b);
        OP_XOR:  r = a ^ b;
        OP_XNOR: r = ~(a ^ b);
        OP_NOT:  r = ~a;
        OP_PASS: r = a;
        OP_ROL:  r = {a[T1-2:0], a[T1-1]};
        OP_ROR:  r = {a[0], a[T1-1:1]};
        default: r = '0;
      endcase
    end

    assign res[k*T1 +: T1] = r;

`ifdef ALU_FLAGS_EN
    logic c;

    // Carry/borrow derived from the truncated result, or the bit shifted out.
    always_comb begin
      c = 1'b0;
      case (op_w)
        OP_ADD:         c = (r < a);
        OP_SUB:         c = (a < b);
        OP_INC:         c = (a == '1);
        OP_DEC:         c = (a == '0);
        OP_SHL, OP_ROL: c = a[T1-1];
        OP_SHR, OP_ROR: c = a[0];
        default:        c = 1'b0;
      endcase
    end

    assign cy[k] = c;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out   <= '0;
`ifdef ALU_FLAGS_EN
      bus.zero  <= 1'b0;
      bus.carry <= '0;
`endif
    end else begin
      bus.out   <= res;
`ifdef ALU_FLAGS_EN
      bus.zero  <= (res == '0);
      bus.carry <= cy;
`endif
    end
  end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes model expectations, monitor pops and compares each cycle.
module tb_alu;
  localparam int unsigned S  = 5;
  localparam int unsigned T1 = 8;
  localparam int unsigned T2 = 2;
  localparam int unsigned W  = T1 * T2;

  typedef struct packed {
    logic [W-1:0]  out;
`ifdef ALU_FLAGS_EN
    logic          zero;
    logic [T2-1:0] carry;
`endif
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q[$];

  alu_if #(.S(S), .T1(T1), .T2(T2)) bus ();

  alu #(.S(S), .T1(T1), .T2(T2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-lane plain integer arithmetic modulo 2^T1.
  function automatic exp_t model(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   m;
    int   a;
    int   b;
    int   v;
    int   c;
    e = '0;
    m = 1 << T1;
    for (int k = 0; k < int'(T2); k++) begin
      a = int'(x[k*T1 +: T1]);
      b = int'(y[k*T1 +: T1]);
      c = 0;
      case (op)
        0:  begin v = (a + b) % m;     c = ((a + b) >= m) ? 1 : 0; end
        1:  begin v = (a - b + m) % m; c = (a < b) ? 1 : 0;        end
        2:  begin v = (a + 1) % m;     c = (a == m - 1) ? 1 : 0;   end
        3:  begin v = (a - 1 + m) % m; c = (a == 0) ? 1 : 0;       end
        4:  begin v = (a * 2) % m;     c = a / (m / 2);            end
        5:  begin v = a / 2;           c = a % 2;                  end
        6:  v = a & b;
        7:  v = (m - 1) - (a & b);
        8:  v = a | b;
        9:  v = (m - 1) - (a | b);
        10: v = a ^ b;
        11: v = (m - 1) - (a ^ b);
        12: v = (m - 1) - a;
        13: v = a;
        14: begin v = (a * 2) % m + a / (m / 2); c = a / (m / 2); end
        15: begin v = a / 2 + (a % 2) * (m / 2); c = a % 2;       end
        default: v = 0;
      endcase
      e.out[k*T1 +: T1] = T1'(v);
`ifdef ALU_FLAGS_EN
      e.carry[k] = (c != 0);
`endif
    end
`ifdef ALU_FLAGS_EN
    e.zero = (e.out == '0);
`endif
    return e;
  endfunction

  task automatic step(input int op, input logic [W-1:0] x, input logic [W-1:0] y, input logic rst);
    @(negedge clk);
    bus.op  = S'(op);
    bus.in1 = x;
    bus.in2 = y;
    reset   = rst;
    if (rst) q.push_back('0);
    else     q.push_back(model(op, x, y));
  endtask

  // Monitor: the DUT presents a result every cycle once stimulus has been issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.out !== e.out) begin
          bad++;
          $display("FAIL out: got %h want %h (op=%0d)", bus.out, e.out, bus.op);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (bus.zero !== e.zero || bus.carry !== e.carry) begin
          bad++;
          $display("FAIL flags: got zero=%b carry=%b want zero=%b carry=%b",
                   bus.zero, bus.carry, e.zero, e.carry);
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    bus.op  = '0;
    bus.in1 = '0;
    bus.in2 = '0;

    // Reset then ADD 170+60
    step(0, 16'hAAAA, 16'h3C3C, 1'b1);
    step(0, 16'hAAAA, 16'h3C3C, 1'b0);
    // Logic sweep
    for (int op = 6; op <= 13; op++) step(op, 16'hAAAA, 16'h3C3C, 1'b0);
    // Arithmetic wrap
    step(0, 16'hFFFF, 16'h0101, 1'b0);
    step(1, 16'h0000, 16'h0101, 1'b0);
    step(2, 16'hFF7F, 16'h0000, 1'b0);
    step(3, 16'h0000, 16'h0000, 1'b0);
    // Shift / rotate
    for (int op = 4; op <= 5; op++)   step(op, 16'h8181, 16'h0000, 1'b0);
    for (int op = 14; op <= 15; op++) step(op, 16'h8080, 16'h0000, 1'b0);
    for (int op = 14; op <= 15; op++) step(op, 16'h8181, 16'h0000, 1'b0);
    // Lanes isolated
    step(0, 16'hFF01, 16'h0101, 1'b0);
    // Reset mid-stream
    step(8, 16'hAAAA, 16'h3C3C, 1'b0);
    step(8, 16'hAAAA, 16'h3C3C, 1'b1);
    step(10, 16'hAAAA, 16'h3C3C, 1'b0);
    // Out-of-range opcodes
    for (int op = 16; op <= 31; op++) step(op, 16'h1234, 16'h5678, 1'b0);
    // Randomized traffic with sporadic resets
    for (int i = 0; i < 400; i++) begin
      r1 = W'($urandom);
      r2 = W'($urandom);
      step(int'($urandom_range(0, 31)), r1, r2, ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
